// File: rtl/prog_run_ctrl_pkg.sv
// prog_run_pkg: shared run-controller state encoding and default widths.
package prog_run_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} run_state_t;
   localparam int NUM_PROGS_DEF = 3;
   localparam int PC_W_DEF = 10;
   localparam int CYC_W_DEF = 16;
   localparam int MAX_CYC_DEF = 'hFFFF;
endpackage

// File: rtl/prog_run_ctrl_if.sv
// prog_run_ctrl_if: bench/fetch-side signals of the run controller.
interface prog_run_ctrl_if
   import prog_run_pkg::*;
#(
   parameter int NUM_PROGS = NUM_PROGS_DEF,
   parameter int PC_W = PC_W_DEF,
   parameter int CYC_W = CYC_W_DEF
);
   localparam int SEL_W = $clog2(NUM_PROGS);
   logic start;
   logic [SEL_W-1:0] prog_sel;
   logic [NUM_PROGS*PC_W-1:0] entry_pcs;
   logic halt_in;
   logic pc_load;
   logic [PC_W-1:0] pc_load_val;
   logic pc_en;
   logic busy;
   logic ack;
   logic timed_out;
   logic [CYC_W-1:0] cycle_ct;
   logic [SEL_W-1:0] active_prog;
   modport master (
      output start, prog_sel, entry_pcs, halt_in,
      input pc_load, pc_load_val, pc_en, busy, ack, timed_out, cycle_ct, active_prog
   );
   modport slave (
      input start, prog_sel, entry_pcs, halt_in,
      output pc_load, pc_load_val, pc_en, busy, ack, timed_out, cycle_ct, active_prog
   );
endinterface

// File: rtl/cycle_budget_ctr.sv
// cycle_budget_ctr: saturating run-cycle counter with registered last-cycle flag.
module cycle_budget_ctr
   import prog_run_pkg::*;
#(
   parameter int CYC_W = CYC_W_DEF,
   parameter int MAX_CYC = MAX_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CYC_W-1:0] count,
   output logic             expire
);
   localparam logic [CYC_W-1:0] TOP = CYC_W'(MAX_CYC);
   localparam logic [CYC_W-1:0] LAST = CYC_W'(MAX_CYC - 1);
   logic [CYC_W-1:0] count_q, count_d;
   logic expire_q, expire_d;
   always_comb begin
      count_d = clr ? '0 : (en && count_q != TOP) ? count_q + CYC_W'(1) : count_q;
      expire_d = count_d == LAST;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         expire_q <= 1'b0;
      end else begin
         count_q <= count_d;
         expire_q <= expire_d;
      end
   end
   assign count = count_q;
   assign expire = expire_q;
endmodule

// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: Start/Ack handshake, PC load/enable sequencing and cycle budget for resident programs.
module prog_run_ctrl
   import prog_run_pkg::*;
#(
   parameter int NUM_PROGS = NUM_PROGS_DEF,
   parameter int PC_W = PC_W_DEF,
   parameter int CYC_W = CYC_W_DEF,
   parameter int MAX_CYC = MAX_CYC_DEF
) (
   input logic            clk,
   input logic            rst_n,
   prog_run_ctrl_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_PROGS);
   run_state_t state_q, state_d;
   logic start_q;
   logic [SEL_W-1:0] active_prog_q, active_prog_d;
   logic timed_out_q, timed_out_d;
   logic pc_load_q, pc_load_d, pc_en_q, pc_en_d, busy_q, busy_d, ack_q, ack_d;
   logic clr, cnt_en, expire, launch;
   logic [CYC_W-1:0] count;
   cycle_budget_ctr #(.CYC_W(CYC_W), .MAX_CYC(MAX_CYC)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (cnt_en),
      .count (count),
      .expire(expire)
   );
   assign launch = bus.start && !start_q && int'(bus.prog_sel) < NUM_PROGS;
   always_comb begin
      state_d = state_q;
      active_prog_d = active_prog_q;
      timed_out_d = timed_out_q;
      clr = 1'b0;
      cnt_en = 1'b0;
      unique case (state_q)
         IDLE, DONE: if (launch) begin
            state_d = LOAD;
            active_prog_d = bus.prog_sel;
            timed_out_d = 1'b0;
            clr = 1'b1;
         end
         LOAD: state_d = RUN;
         RUN: begin
            cnt_en = 1'b1;
            // halt takes priority over a budget expiry in the same cycle
            state_d = (bus.halt_in || expire) ? DONE : RUN;
            timed_out_d = !bus.halt_in && expire;
         end
      endcase
      pc_load_d = state_d == LOAD;
      pc_en_d = state_d == RUN;
      busy_d = state_d == LOAD || state_d == RUN;
      ack_d = state_d == DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         active_prog_q <= '0;
         timed_out_q <= 1'b0;
         pc_load_q <= 1'b0;
         pc_en_q <= 1'b0;
         busy_q <= 1'b0;
         ack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= bus.start;
         active_prog_q <= active_prog_d;
         timed_out_q <= timed_out_d;
         pc_load_q <= pc_load_d;
         pc_en_q <= pc_en_d;
         busy_q <= busy_d;
         ack_q <= ack_d;
      end
   end
   // the halt instruction itself must not advance the PC
   assign bus.pc_en = pc_en_q && !bus.halt_in;
   assign bus.pc_load = pc_load_q;
   assign bus.pc_load_val = bus.entry_pcs[int'(active_prog_q)*PC_W +: PC_W];
   assign bus.busy = busy_q;
   assign bus.ack = ack_q;
   assign bus.timed_out = timed_out_q;
   assign bus.cycle_ct = count;
   assign bus.active_prog = active_prog_q;
endmodule
